// File: rtl/mem_responder_if.sv
// Initiator/responder bus for mem_responder: held request level in, one-cycle resp pulse out.
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency single-outstanding memory responder with byte-lane writes and a
// sticky protocol-error flag; backing store survives reset.
//
// state  | meaning
// S_IDLE | ready; a live read/write request is accepted on the next edge
// S_WAIT | request latched, latency down-counter running; dropped request aborts
// S_DONE | one-cycle mem_resp pulse; held requests are ignored here
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus,
  output logic            busy_o,
  output logic            proto_err_o
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            wr_q;
  logic            resp_q;
  logic            busy_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            req_live;
  logic            commit_wr;
  logic            unused_addr_bits;

  assign req_live  = bus.mem_read | bus.mem_write;
  assign commit_wr = (state_q == S_WAIT) && req_live && (cnt_q == 4'd0) && wr_q;

  // Address bits outside the word index alias by design.
  assign unused_addr_bits = ^{bus.mem_address[31:AW+2], bus.mem_address[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_live) begin
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
            idx_q   <= bus.mem_address[AW+1:2];
            wdata_q <= bus.mem_wdata;
            be_q    <= bus.mem_byte_enable;
            wr_q    <= bus.mem_write;
            if (bus.mem_read && bus.mem_write) begin
              err_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!req_live) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
            resp_q  <= 1'b1;
            if (!wr_q) begin
              rdata_q <= mem_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Store has no reset so contents persist across rst_n pulses.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_resp  = resp_q;
  assign busy_o        = busy_q;
  assign proto_err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model checked every cycle, plus
// directed transactions with literal expected data and latency.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if if3 ();
  mem_responder_if if1 ();
  logic busy3, err3, busy1, err1;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(if3), .busy_o(busy3), .proto_err_o(err3)
  );
  mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .busy_o(busy1), .proto_err_o(err1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  // Inputs as seen by each rising edge taken out of reset
  int pe_cnt = 0;
  int rst_cnt = 0;
  logic        s_rd, s_wr;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wd;

  always @(posedge clk) begin
    if (rst_n) begin
      pe_cnt <= pe_cnt + 1;
      s_rd   <= if3.mem_read;
      s_wr   <= if3.mem_write;
      s_be   <= if3.mem_byte_enable;
      s_addr <= if3.mem_address;
      s_wd   <= if3.mem_wdata;
    end
  end

  always @(negedge rst_n) rst_cnt <= rst_cnt + 1;

  // Model: one pending transaction completing LATENCY edges after acceptance
  initial begin : cmp
    int seen_pe = 0;
    int seen_rst = 0;
    int ecnt = 0;
    int done_at = 0;
    int p_idx = 0;
    bit pend = 0, m_resp = 0, m_err = 0, p_wr = 0, was_done = 0;
    logic [31:0] m_rdata = 32'd0;
    logic [31:0] p_wd = 32'd0;
    logic [3:0]  p_be = 4'd0;
    logic [31:0] mem_m [256];
    forever begin
      @(negedge clk);
      if (rst_cnt != seen_rst || !rst_n) begin
        seen_rst = rst_cnt;
        pend = 0; m_resp = 0; m_err = 0; m_rdata = 32'd0;
      end
      if (pe_cnt != seen_pe) begin
        seen_pe = pe_cnt;
        ecnt++;
        was_done = m_resp;
        m_resp = 0;
        if (pend) begin
          if (!s_rd && !s_wr) begin
            pend = 0;
            m_err = 1;
          end else if (ecnt == done_at) begin
            pend = 0;
            m_resp = 1;
            if (p_wr) begin
              for (int i = 0; i < 4; i++)
                if (p_be[i]) mem_m[p_idx][8*i +: 8] = p_wd[8*i +: 8];
            end else begin
              m_rdata = mem_m[p_idx];
            end
          end
        end else if (!was_done && (s_rd || s_wr)) begin
          pend = 1;
          done_at = ecnt + 3;
          p_wr = s_wr;
          p_idx = int'((s_addr % 32'd1024) / 32'd4);
          p_wd = s_wd;
          p_be = s_be;
          if (s_rd && s_wr) m_err = 1;
        end
      end
      chk("model_resp", 32'(if3.mem_resp), 32'(m_resp));
      chk("model_busy", 32'(busy3), 32'(pend || m_resp));
      chk("model_err", 32'(err3), 32'(m_err));
      if (!(m_resp && p_wr)) chk("model_rdata", if3.mem_rdata, m_rdata);
    end
  end

  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rdat, output int lat);
    @(negedge clk);
    if3.mem_read = rd;
    if3.mem_write = wr;
    if3.mem_address = addr;
    if3.mem_wdata = wd;
    if3.mem_byte_enable = be;
    lat = 0;
    rdat = 32'd0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (if3.mem_resp) begin
        lat = n;
        rdat = if3.mem_rdata;
        break;
      end
      if (n == 1) begin
        if3.mem_address = ~addr;
        if3.mem_wdata = ~wd;
        if3.mem_byte_enable = ~be;
      end
    end
    if3.mem_read = 1'b0;
    if3.mem_write = 1'b0;
    if (lat == 0) begin
      total++;
      bad++;
      $display("FAIL txn_timeout addr=%08h no mem_resp within 40 cycles", addr);
    end
  endtask

  initial begin : stim
    logic [31:0] rd;
    int lat;
    int pulses;
    if3.mem_read = 1'b0; if3.mem_write = 1'b0; if3.mem_byte_enable = 4'h0;
    if3.mem_address = 32'd0; if3.mem_wdata = 32'd0;
    if1.mem_read = 1'b0; if1.mem_write = 1'b0; if1.mem_byte_enable = 4'h0;
    if1.mem_address = 32'd0; if1.mem_wdata = 32'd0;

    repeat (3) @(negedge clk);
    chk("reset_resp", 32'(if3.mem_resp), 32'd0);
    chk("reset_busy", 32'(busy3), 32'd0);
    chk("reset_err", 32'(err3), 32'd0);
    chk("reset_rdata", if3.mem_rdata, 32'd0);
    #2 rst_n = 1'b1;

    txn(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd, lat);
    chk("write_latency", 32'(lat), 32'd4);
    txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd, lat);
    chk("read_latency", 32'(lat), 32'd4);
    chk("read_deadbeef", rd, 32'hDEADBEEF);

    txn(1'b0, 1'b1, 32'h40, 32'h11223344, 4'b0101, rd, lat);
    txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd, lat);
    chk("partial_lanes", rd, 32'hDE22BE44);

    txn(1'b0, 1'b1, 32'h0, 32'h0000CAFE, 4'hF, rd, lat);
    txn(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, rd, lat);
    chk("alias_read", rd, 32'h0000CAFE);

    txn(1'b0, 1'b1, 32'h83, 32'hA5A5A5A5, 4'hF, rd, lat);
    txn(1'b0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'b1000, rd, lat);
    txn(1'b1, 1'b0, 32'h81, 32'h0, 4'h0, rd, lat);
    chk("top_lane", rd, 32'hFFA5A5A5);

    // Write dropped one cycle into WAIT
    @(negedge clk);
    if3.mem_write = 1'b1; if3.mem_address = 32'h40;
    if3.mem_wdata = 32'h55555555; if3.mem_byte_enable = 4'hF;
    @(negedge clk);
    @(negedge clk);
    if3.mem_write = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if3.mem_resp) pulses++;
    end
    chk("abort_no_resp", 32'(pulses), 32'd0);
    chk("abort_err", 32'(err3), 32'd1);
    chk("abort_busy", 32'(busy3), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("rst_clears_err", 32'(err3), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd, lat);
    chk("abort_word_kept", rd, 32'hDE22BE44);

    txn(1'b1, 1'b1, 32'h44, 32'h12345678, 4'hF, rd, lat);
    chk("both_high_err", 32'(err3), 32'd1);
    txn(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, rd, lat);
    chk("both_high_is_write", rd, 32'h12345678);

    // Reset during WAIT of a write
    @(negedge clk);
    if3.mem_write = 1'b1; if3.mem_address = 32'h40;
    if3.mem_wdata = 32'hAAAAAAAA; if3.mem_byte_enable = 4'hF;
    @(negedge clk);
    chk("wait_busy", 32'(busy3), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_busy_now", 32'(busy3), 32'd0);
    chk("rst_resp_now", 32'(if3.mem_resp), 32'd0);
    if3.mem_write = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd, lat);
    chk("rst_write_discarded", rd, 32'hDE22BE44);

    // LATENCY=1 instance with a continuously held read
    @(negedge clk);
    if1.mem_read = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("l1_resp_pattern", 32'(if1.mem_resp), 32'((i % 3) == 1));
      if (if1.mem_resp) pulses++;
    end
    if1.mem_read = 1'b0;
    chk("l1_pulse_count", 32'(pulses), 32'd7);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
